// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
//  Module      : serial_add_ctrl_if
//  Description : Handshake and data bundle for the bit-serial adder controller.
//                master modport = requester side, slave modport = adder side.
//  Signals     : start     request to begin an operation        (master->slave)
//                in_ready  start will be accepted this cycle     (slave->master)
//                a, b      WIDTH-bit operands                    (master->slave)
//                cin       carry-in                              (master->slave)
//                sub       subtract select (SERIAL_ADD_SUBTRACT_EN only)
//                busy      bits are being processed              (slave->master)
//                done      one-cycle completion pulse            (slave->master)
//                sum       WIDTH-bit result, held                (slave->master)
//                cout      final carry-out, held                 (slave->master)
//  Config      : `define SERIAL_ADD_SUBTRACT_EN adds the sub signal.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_SUBTRACT_EN
  logic             sub;

  modport master (
    output start, a, b, cin, sub,
    input  in_ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin, sub,
    output in_ready, busy, done, sum, cout
  );
`else
  modport master (
    output start, a, b, cin,
    input  in_ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output in_ready, busy, done, sum, cout
  );
`endif
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
//  Module      : serial_add_ctrl (with helper cell full_adder)
//  Description : Bit-serial adder controller. Captures two WIDTH-bit operands
//                and a carry-in, then runs one full-adder cell LSB-first over
//                WIDTH clock edges. Carry is held in a flip-flop between bits.
//                The result and carry-out are registered and flagged by a
//                one-cycle done pulse.
//  Ports       : clk   rising-edge clock
//                rst   synchronous active-high reset
//                bus   serial_add_ctrl_if.slave
//                      (start, in_ready, a, b, cin, [sub], busy, done, sum, cout)
//  Parameters  : WIDTH operand/result width, 1..32 (default 8)
//  Config      : `define SERIAL_ADD_SUBTRACT_EN enables subtraction via bus.sub:
//                B is loaded inverted and carry preset to 1 (cin ignored);
//                cout=1 then means "no borrow".
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// 1-bit full-adder cell
// ----------------------------------------------------------------------------
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (z & (x ^ y));
endmodule

// ----------------------------------------------------------------------------
// Sequencing controller
// ----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_q;

  full_adder u_fa (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .z (carry),
    .s (fa_s),
    .c (fa_c)
  );

  assign accept   = (state == IDLE) && bus.start;
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  // The new bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_next = fa_s;
    end else begin : g_sum_wn
      assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand shifters, carry FF, bit counter and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_sh   <= bus.a;
        sum_sh <= '0;
        cnt    <= '0;
`ifdef SERIAL_ADD_SUBTRACT_EN
        // a - b computed as a + ~b + 1
        b_sh   <= bus.sub ? ~bus.b : bus.b;
        carry  <= bus.sub ? 1'b1 : bus.cin;
`else
        b_sh   <= bus.b;
        carry  <= bus.cin;
`endif
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_next;
        carry  <= fa_c;
        cnt    <= cnt + 1'b1;
        if (last_bit) begin
          sum_q  <= sum_next;
          cout_q <= fa_c;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
//                Inputs change and outputs are sampled 1 time unit after
//                each rising clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bif ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Running count of done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (bif.done === 1'b1) done_seen = done_seen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an operation, then follow it to completion checking latency,
  // busy duration and the result.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    int n;
    int busy_cycles;
    n = 0;
    while (bif.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: in_ready=%b required 1", name, bif.in_ready);
    end
    bif.start = 1'b1;
    bif.a     = a;
    bif.b     = b;
    bif.cin   = cin;
    tick();
    bif.start = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (bif.done !== 1'b1 && n < 50) begin
      if (bif.busy === 1'b1) busy_cycles++;
      tick();
      n++;
    end
    checks++;
    if (n !== WIDTH) begin
      errors++;
      $display("FAIL %s latency: done after %0d edges required %0d", name, n, WIDTH);
    end
    checks++;
    if (busy_cycles !== WIDTH) begin
      errors++;
      $display("FAIL %s busy_len: busy for %0d cycles required %0d", name, busy_cycles, WIDTH);
    end
    checks++;
    if (bif.sum !== exp_sum) begin
      errors++;
      $display("FAIL %s sum: got %h required %h", name, bif.sum, exp_sum);
    end
    checks++;
    if (bif.cout !== exp_cout) begin
      errors++;
      $display("FAIL %s cout: got %b required %b", name, bif.cout, exp_cout);
    end
    tick();
    checks++;
    if (bif.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b one cycle later required 0", name, bif.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", bif.busy); end
    checks++;
    if (bif.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b required 0", bif.done); end
    checks++;
    if (bif.sum !== 8'h00) begin errors++; $display("FAIL reset sum: got %h required 00", bif.sum); end
    checks++;
    if (bif.cout !== 1'b0) begin errors++; $display("FAIL reset cout: got %b required 0", bif.cout); end
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b required 1", bif.in_ready); end
  endtask

  task automatic test_basic_add();
    run_op("basic_3C_25", 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0);
  endtask

  task automatic test_carry_chain();
    run_op("carry_FF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("carry_FF_FF_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
  endtask

  task automatic test_ignored_start();
    int base;
    base = done_seen;
    bif.start = 1'b1;
    bif.a = 8'h10;
    bif.b = 8'h20;
    bif.cin = 1'b0;
    tick();
    bif.start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL ignored in_ready: got %b required 0", bif.in_ready); end
    bif.start = 1'b1;
    bif.a = 8'h77;
    bif.b = 8'h77;
    tick();
    bif.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (bif.sum !== 8'h30) begin errors++; $display("FAIL ignored sum: got %h required 30", bif.sum); end
    checks++;
    if (done_seen - base !== 1) begin
      errors++;
      $display("FAIL ignored done_count: got %0d pulses required 1", done_seen - base);
    end
    checks++;
    if (bif.busy !== 1'b0) begin errors++; $display("FAIL ignored busy_after: got %b required 0", bif.busy); end
  endtask

  task automatic test_reset_mid_op();
    int base;
    base = done_seen;
    bif.start = 1'b1;
    bif.a = 8'hAA;
    bif.b = 8'h55;
    bif.cin = 1'b0;
    tick();
    bif.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bif.busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b required 0", bif.busy); end
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL midrst in_ready: got %b required 1", bif.in_ready); end
    checks++;
    if (bif.sum !== 8'h00) begin errors++; $display("FAIL midrst sum: got %h required 00", bif.sum); end
    checks++;
    if (bif.cout !== 1'b0) begin errors++; $display("FAIL midrst cout: got %b required 0", bif.cout); end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (done_seen - base !== 0) begin
      errors++;
      $display("FAIL midrst done_count: got %0d pulses required 0", done_seen - base);
    end
    run_op("after_rst_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
  endtask

  // The done cycle is an IDLE cycle, so the held start is taken at the edge
  // that closes it; the second done then appears WIDTH edges later, i.e.
  // WIDTH+1 cycles after the first.
  task automatic test_back_to_back();
    int n;
    bif.start = 1'b1;
    bif.a = 8'h05;
    bif.b = 8'h06;
    bif.cin = 1'b0;
    tick();
    bif.a = 8'h80;
    bif.b = 8'h80;
    n = 0;
    while (bif.done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (bif.sum !== 8'h0B || bif.cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b first: got %h/%b required 0B/0", bif.sum, bif.cout);
    end
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL b2b ready_in_done: got %b required 1", bif.in_ready); end
    tick();
    bif.start = 1'b0;
    checks++;
    if (bif.busy !== 1'b1) begin errors++; $display("FAIL b2b second_accept: busy=%b required 1", bif.busy); end
    n = 1;
    while (bif.done !== 1'b1 && n < 50) begin
      checks++;
      if (bif.sum !== 8'h0B) begin errors++; $display("FAIL b2b sum_hold: got %h required 0B", bif.sum); end
      tick();
      n++;
    end
    checks++;
    if (n !== WIDTH + 1) begin errors++; $display("FAIL b2b spacing: got %0d cycles required %0d", n, WIDTH + 1); end
    checks++;
    if (bif.sum !== 8'h00 || bif.cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b second: got %h/%b required 00/1", bif.sum, bif.cout);
    end
    tick();
  endtask

`ifdef SERIAL_ADD_SUBTRACT_EN
  task automatic test_subtract();
    bif.sub = 1'b1;
    run_op("sub_10_03", 8'h10, 8'h03, 1'b0, 8'h0D, 1'b1);
    run_op("sub_03_10", 8'h03, 8'h10, 1'b0, 8'hF3, 1'b0);
    bif.sub = 1'b0;
    run_op("add_03_10_c1", 8'h03, 8'h10, 1'b1, 8'h14, 1'b0);
  endtask
`endif

  initial begin
    bif.start = 1'b0;
    bif.a     = '0;
    bif.b     = '0;
    bif.cin   = 1'b0;
`ifdef SERIAL_ADD_SUBTRACT_EN
    bif.sub   = 1'b0;
`endif
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
`ifdef SERIAL_ADD_SUBTRACT_EN
    test_subtract();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
